// File: rtl/usart_pkg.sv
// Shared constants for the USART baud/oversample tick generator.
// The fractional-divisor width is only used when USART_BAUD_FRAC_EN is defined.
package usart_pkg;

  localparam int USART_OVERSAMPLE      = 16;
  localparam int USART_DIV_WIDTH       = 32;
  localparam int OS_CNT_WIDTH          = $clog2(USART_OVERSAMPLE);
  localparam int USART_BAUD_FRAC_WIDTH = 4;

endpackage

// File: rtl/usart_baud_gen_cmp.sv
// Unsigned magnitude comparator: equal/greater/lower of data_0_i against data_1_i.
module usart_baud_gen_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_0_i,
  input  logic [WIDTH-1:0] data_1_i,
  output logic             equal_o,
  output logic             greater_o,
  output logic             lower_o
);

  assign equal_o   = (data_0_i == data_1_i);
  assign greater_o = (data_0_i >  data_1_i);
  assign lower_o   = (data_0_i <  data_1_i);

endmodule

// File: rtl/usart_baud_gen.sv
// Baud/oversample tick generator: sample, bit and mid-bit enables for the USART engines.
// Optional fractional divisor (frac_i, 1/16 units) enabled by defining USART_BAUD_FRAC_EN.
module usart_baud_gen
  import usart_pkg::*;
#(
  parameter int DATA_WIDTH      = USART_DIV_WIDTH,
  parameter int OVERSAMPLE      = USART_OVERSAMPLE,
  parameter int DEFAULT_DIVISOR = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic [DATA_WIDTH-1:0]            divisor_i,
  input  logic                             divisor_load_i,
  input  logic                             sync_i,
`ifdef USART_BAUD_FRAC_EN
  input  logic [USART_BAUD_FRAC_WIDTH-1:0] frac_i,
`endif
  output logic                             sample_tick_o,
  output logic                             bit_tick_o,
  output logic                             mid_tick_o
);

  localparam int                    OS_W    = $clog2(OVERSAMPLE);
  localparam logic [DATA_WIDTH-1:0] DIV_RST = (DEFAULT_DIVISOR > 1) ?
                                              DATA_WIDTH'(DEFAULT_DIVISOR) : DATA_WIDTH'(1);
  localparam logic [OS_W-1:0]       OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]       OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DATA_WIDTH-1:0] r_div;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [OS_W-1:0]       r_os_cnt;
  logic [DATA_WIDTH-1:0] w_div_clamped;
  logic [DATA_WIDTH-1:0] w_term_cnt;
  logic                  w_term;
  logic                  w_greater;
  logic                  w_lower;
  logic                  w_unused_cmp;

  assign w_div_clamped = (divisor_i > DATA_WIDTH'(1)) ? divisor_i : DATA_WIDTH'(1);

`ifdef USART_BAUD_FRAC_EN
  logic [USART_BAUD_FRAC_WIDTH-1:0] r_acc;
  logic                             r_extra;
  logic [USART_BAUD_FRAC_WIDTH:0]   w_acc_sum;

  // A carry out of the accumulator stretches the following period by one clock.
  assign w_acc_sum  = {1'b0, r_acc} + {1'b0, frac_i};
  assign w_term_cnt = r_div - DATA_WIDTH'(1) + {{(DATA_WIDTH-1){1'b0}}, r_extra};

  always_ff @(posedge clk_i) begin
    if (rst_i || divisor_load_i || sync_i) begin
      r_acc   <= '0;
      r_extra <= 1'b0;
    end else if (sample_tick_o) begin
      {r_extra, r_acc} <= w_acc_sum;
    end
  end
`else
  assign w_term_cnt = r_div - DATA_WIDTH'(1);
`endif

  usart_baud_gen_cmp #(
    .WIDTH(DATA_WIDTH)
  ) u_cmp (
    .data_0_i (r_cnt),
    .data_1_i (w_term_cnt),
    .equal_o  (w_term),
    .greater_o(w_greater),
    .lower_o  (w_lower)
  );

  assign w_unused_cmp = w_greater ^ w_lower;

  // Strobe cycles swallow any coincident terminal count.
  assign sample_tick_o = en_i & w_term & ~sync_i & ~divisor_load_i & ~rst_i;
  assign bit_tick_o    = sample_tick_o & (r_os_cnt == OS_LAST);
  assign mid_tick_o    = sample_tick_o & (r_os_cnt == OS_MID);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div    <= DIV_RST;
      r_cnt    <= '0;
      r_os_cnt <= '0;
    end else if (divisor_load_i) begin
      r_div    <= w_div_clamped;
      r_cnt    <= '0;
      r_os_cnt <= '0;
    end else if (sync_i) begin
      r_cnt    <= '0;
      r_os_cnt <= '0;
    end else if (en_i) begin
      if (sample_tick_o) begin
        r_cnt    <= '0;
        r_os_cnt <= r_os_cnt + OS_W'(1);
      end else begin
        r_cnt    <= r_cnt + DATA_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_usart_baud_gen.sv
// Directed bench for usart_baud_gen (OVERSAMPLE 16, DEFAULT_DIVISOR 1).
// Define USART_BAUD_FRAC_EN to also exercise the fractional divisor.
module tb_usart_baud_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] divisor;
  logic        load;
  logic        sync;
  logic        s_tick;
  logic        b_tick;
  logic        m_tick;
`ifdef USART_BAUD_FRAC_EN
  logic [3:0]  frac;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  usart_baud_gen #(
    .DATA_WIDTH     (32),
    .OVERSAMPLE     (16),
    .DEFAULT_DIVISOR(1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .divisor_i     (divisor),
    .divisor_load_i(load),
    .sync_i        (sync),
`ifdef USART_BAUD_FRAC_EN
    .frac_i        (frac),
`endif
    .sample_tick_o (s_tick),
    .bit_tick_o    (b_tick),
    .mid_tick_o    (m_tick)
  );

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // One clock: outputs checked mid-cycle, then the edge that commits this cycle.
  task automatic step(input string tag, input int k, input logic es, input logic eb, input logic em);
    @(negedge clk);
    chk({tag, ".sample"}, k, s_tick, es);
    chk({tag, ".bit"},    k, b_tick, eb);
    chk({tag, ".mid"},    k, m_tick, em);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; divisor = 32'd0; load = 1'b0; sync = 1'b0;
`ifdef USART_BAUD_FRAC_EN
    frac = 4'd0;
`endif
    for (int k = 1; k <= 3; k++) step("reset", k, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    $display("phase: default divisor 1");
    for (int k = 1; k <= 32; k++) step("div1", k, 1'b1, (k % 16) == 0, (k % 16) == 8);

    $display("phase: divisor 4 periodicity");
    divisor = 32'd4; load = 1'b1; step("load4", 0, 1'b0, 1'b0, 1'b0); load = 1'b0;
    for (int k = 1; k <= 128; k++) step("div4", k, (k % 4) == 0, (k % 64) == 0, (k % 64) == 32);

    $display("phase: divisor 0 clamp");
    divisor = 32'd0; load = 1'b1; step("load0", 0, 1'b0, 1'b0, 1'b0); load = 1'b0;
    for (int k = 1; k <= 32; k++) step("clamp", k, 1'b1, (k % 16) == 0, (k % 16) == 8);

    $display("phase: enable gap, divisor 10");
    divisor = 32'd10; load = 1'b1; step("load10", 0, 1'b0, 1'b0, 1'b0); load = 1'b0;
    for (int k = 1; k <= 5; k++) step("gap_pre", k, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    for (int k = 1; k <= 7; k++) step("gap", k, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 5; k++) step("gap_post", k, k == 5, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) step("gap_next", k, k == 10, 1'b0, 1'b0);

    $display("phase: sync on terminal count, divisor 8");
    divisor = 32'd8; load = 1'b1; step("load8", 0, 1'b0, 1'b0, 1'b0); load = 1'b0;
    for (int k = 1; k <= 7; k++) step("sync_pre", k, 1'b0, 1'b0, 1'b0);
    sync = 1'b1; step("sync_strobe", 0, 1'b0, 1'b0, 1'b0); sync = 1'b0;
    for (int k = 1; k <= 64; k++) step("sync_post", k, (k % 8) == 0, 1'b0, k == 64);

    $display("phase: load+sync priority, divisor 3");
    for (int k = 1; k <= 2; k++) step("prio_pre", k, 1'b0, 1'b0, 1'b0);
    divisor = 32'd3; load = 1'b1; sync = 1'b1;
    step("prio_strobe", 0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; sync = 1'b0;
    for (int k = 1; k <= 48; k++) step("div3", k, (k % 3) == 0, k == 48, k == 24);

    $display("phase: enable low on terminal count");
    for (int k = 1; k <= 2; k++) step("hold_pre", k, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    for (int k = 1; k <= 2; k++) step("hold", k, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    step("hold_resume", 1, 1'b1, 1'b0, 1'b0);
    step("hold_after", 1, 1'b0, 1'b0, 1'b0);

`ifdef USART_BAUD_FRAC_EN
    $display("phase: fractional divisor 4 + 8/16");
    frac = 4'd8; divisor = 32'd4; load = 1'b1;
    step("load_frac", 0, 1'b0, 1'b0, 1'b0); load = 1'b0;
    for (int k = 1; k <= 22; k++)
      step("frac", k, (k == 4) || (k == 8) || (k == 13) || (k == 17) || (k == 22), 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usart_baud_gen.md
Name: usart_baud_gen

Overview:
Baud/oversample tick generator for the AXI USART. It counts system clocks against a programmable divisor and emits single-cycle enables to the RX and TX shift engines: a sample tick (OVERSAMPLE x baud), a bit tick and a mid-bit tick. The counter-versus-terminal-count decision is made by the team's existing comparator block. It sits between the AXI register file (divisor source) and the USART RX/TX state machines.

Parameters:
DATA_WIDTH, 32, width of divisor and clock counter
OVERSAMPLE, 16, sample ticks per bit; power of two, at least 4
DEFAULT_DIVISOR, 1, value loaded into the divisor shadow at reset

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
en_i  in  1  run enable; low freezes counters
divisor_i  in  DATA_WIDTH  clocks per sample tick
divisor_load_i  in  1  one-cycle strobe; captures divisor_i
sync_i  in  1  one-cycle strobe; re-phases counters (RX start-bit edge)
sample_tick_o  out  1  one-cycle pulse per sample period
bit_tick_o  out  1  one-cycle pulse per bit period
mid_tick_o  out  1  one-cycle pulse at bit centre

Behaviour:
- State:
  - div_q: divisor shadow, DATA_WIDTH.
  - cnt: DATA_WIDTH.
  - os_cnt: log2(OVERSAMPLE) bits.
- Reset (rst_i high at an edge):
  - div_q <= max(DEFAULT_DIVISOR, 1); cnt <= 0; os_cnt <= 0.
  - All outputs are 0 while rst_i is high.
  - Reset mid-count discards the partial period.
- Divisor clamp: a divisor_i of 0 or 1 loads as 1, so a sample tick occurs every enabled cycle. No other saturation applies.
- Terminal count: term = (cnt == div_q - 1), with unsigned width DATA_WIDTH.
- Tick outputs (combinational from registers):
  - sample_tick_o = en_i & term & ~sync_i & ~divisor_load_i.
  - bit_tick_o = sample_tick_o & (os_cnt == OVERSAMPLE-1).
  - mid_tick_o = sample_tick_o & (os_cnt == OVERSAMPLE/2-1).
- Counting with en_i high:
  - Without a tick, cnt <= cnt+1.
  - On sample_tick_o, cnt <= 0 and os_cnt <= os_cnt+1; os_cnt wraps from OVERSAMPLE-1 to 0.
- Latency: with en_i high from the first edge after reset, the first sample_tick_o occurs on the div_q-th enabled cycle. The first bit_tick_o occurs on cycle div_q*OVERSAMPLE and the first mid_tick_o on cycle div_q*OVERSAMPLE/2.
- en_i low: cnt and os_cnt hold and all ticks are 0. Resuming continues the partial period with no lost or extra cycles.
- Priority at an edge: rst_i > divisor_load_i > sync_i > en_i.
  - divisor_load_i: div_q <= clamp(divisor_i), cnt <= 0, os_cnt <= 0. It acts regardless of en_i.
  - sync_i: cnt <= 0, os_cnt <= 0. It acts regardless of en_i.
  - In the strobe cycle, ticks are suppressed even if term is true.
- Simultaneous divisor_load_i and sync_i: the load wins; the outcome is identical because both clear the counters.
- Divisor change takes effect for the period that begins after the load cycle. It is never applied mid-period.

Optional Feature:
USART_BAUD_FRAC_EN
- With the macro defined:
  - Adds a port frac_i, input, 4 bits, giving a fractional divisor in 1/16 units.
  - A 4-bit accumulator adds frac_i on each sample tick. When the addition carries, the next sample period is div_q+1 cycles, so the average period is div_q + frac_i/16.
  - The accumulator clears on rst_i, divisor_load_i and sync_i.
- Without the macro: no port, no accumulator; behaviour is exactly as above.

Decomposition:
- Package usart_pkg holds:
  - Default constants USART_OVERSAMPLE = 16 and USART_DIV_WIDTH = 32.
  - A localparam-derived OS_CNT_WIDTH = $clog2(OVERSAMPLE).
  - The USART_BAUD_FRAC_WIDTH = 4 constant.
- Sub-module: one instance of the existing comparator.
  - data_0_i = cnt, data_1_i = div_q - 1 (with the carry adjustment when USART_BAUD_FRAC_EN is defined).
  - equal_o gives term; greater_o and lower_o are unused.
- Counters and strobe logic live in usart_baud_gen.

Test Plan:
- Reset: rst_i high for 3 cycles with en_i high -> all ticks 0, then with DEFAULT_DIVISOR=1 sample_tick_o high on every cycle after release.
- Periodicity: load divisor 4, OVERSAMPLE 16, en_i held -> sample_tick_o every 4 cycles, mid_tick_o first at cycle 32, bit_tick_o first at cycle 64 then every 64; the bit tick coincides with the 16th sample tick.
- Clamp: load divisor 0 -> identical to divisor 1, with sample_tick_o continuously high and bit_tick_o every 16 cycles.
- Enable gap: divisor 10, drop en_i for 7 cycles at cnt=5 -> no ticks during the gap, and the next sample_tick_o arrives 5 enabled cycles after resume.
- Sync: divisor 8, assert sync_i on a term cycle -> no tick that cycle, the next sample_tick_o comes 8 cycles later, and mid_tick_o comes 64 cycles after sync.
- Load priority: divisor_load_i (divisor 3) and sync_i together at mid-count -> next sample_tick_o at cycle 3 after the load; with USART_BAUD_FRAC_EN defined, divisor 4 and frac_i 8 alternate periods of 4 and 5 cycles.
